oversampling_edge_serializer: RTL and testbench

Transmit-side counterpart of the oversampling deserializer/edge detector pair. It turns a stream of edge-to-edge intervals, in units of 1/64 of a CLK_PARALLEL cycle, into 64-bit oversampled parallel words for the 64:1 serializer driving an excitation or test output pin. Bit positions and the edge report match the detector's CHANGED_FLAG/CHANGED_BIT convention, so the serializer output can be looped back into the detector and compared bit-exactly.

---
 rtl/oversampling_edge_serializer.sv | 160 ++++++++++++++++
 tb/tb_oversampling_edge_serializer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/oversampling_edge_serializer.sv
// Interval-to-oversampled-word serializer; one edge per 64-sample word at most.
// Optional EDGE_COUNT output: define OVERSAMPLING_SERIALIZER_EDGE_COUNT_EN.
module oversampling_edge_serializer #(
  parameter int DELAY_WIDTH = 20
) (
  input  logic                   CLK_PARALLEL,
  input  logic                   RESET,
  input  logic                   ENABLE,
  input  logic                   DELAY_VALID,
  output logic                   DELAY_READY,
  input  logic [DELAY_WIDTH-1:0] DELAY_IN,
  output logic [63:0]            PARALLEL_OUT,
  output logic                   EDGE_FLAG,
  output logic [5:0]             EDGE_BIT,
  output logic                   UNDERRUN
`ifdef OVERSAMPLING_SERIALIZER_EDGE_COUNT_EN
  ,
  output logic [31:0]            EDGE_COUNT
`endif
);

  localparam int TW = DELAY_WIDTH + 1;

  typedef enum logic {
    S_IDLE,
    S_ARMED
  } state_e;

  state_e                 state_q, state_d;
  logic [TW-1:0]          t_q, t_d;
  logic                   lvl_q, lvl_d;
  logic                   nxt_vld_q, nxt_vld_d;
  logic [DELAY_WIDTH-1:0] nxt_val_q, nxt_val_d;
  logic [63:0]            word_q, word_d;
  logic                   eflag_q, eflag_d;
  logic [5:0]             ebit_q, ebit_d;
  logic                   under_q, under_d;

  logic                   consume;
  logic                   t_low;
  logic [5:0]             pos;
  logic [63:0]            hi_mask;
  logic [DELAY_WIDTH-1:0] din_clamped;
  logic [TW-1:0]          nxt_ext;

  // Intervals shorter than one word would allow two edges per word.
  assign din_clamped = (DELAY_IN < DELAY_WIDTH'(64)) ?
                       DELAY_WIDTH'(64) : DELAY_IN;

  assign nxt_ext = {1'b0, nxt_val_q};
  assign t_low   = (t_q < TW'(64));
  assign pos     = t_q[5:0];
  assign hi_mask = {64{1'b1}} << pos;

  always_comb begin
    state_d   = state_q;
    t_d       = t_q;
    lvl_d     = lvl_q;
    nxt_vld_d = nxt_vld_q;
    nxt_val_d = nxt_val_q;
    word_d    = {64{lvl_q}};
    eflag_d   = 1'b0;
    ebit_d    = 6'd0;
    under_d   = under_q;
    consume   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ENABLE && nxt_vld_q) begin
          t_d     = nxt_ext;
          consume = 1'b1;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (!t_low) begin
          t_d = t_q - TW'(64);
        end else begin
          word_d  = lvl_q ? ~hi_mask : hi_mask;
          eflag_d = 1'b1;
          ebit_d  = pos;
          lvl_d   = ~lvl_q;
          if (ENABLE) begin
            if (nxt_vld_q) begin
              // Re-basing on t_q keeps edges exact with no drift.
              t_d     = t_q + nxt_ext - TW'(64);
              consume = 1'b1;
            end else begin
              under_d = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        if (!ENABLE) begin
          t_d     = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    DELAY_READY = !RESET && (!nxt_vld_q || consume);

    if (consume) begin
      nxt_vld_d = 1'b0;
    end
    if (DELAY_VALID && DELAY_READY) begin
      nxt_vld_d = 1'b1;
      nxt_val_d = din_clamped;
    end
  end

  always_ff @(posedge CLK_PARALLEL) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      t_q       <= '0;
      lvl_q     <= 1'b0;
      nxt_vld_q <= 1'b0;
      nxt_val_q <= '0;
      word_q    <= '0;
      eflag_q   <= 1'b0;
      ebit_q    <= 6'd0;
      under_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      lvl_q     <= lvl_d;
      nxt_vld_q <= nxt_vld_d;
      nxt_val_q <= nxt_val_d;
      word_q    <= word_d;
      eflag_q   <= eflag_d;
      ebit_q    <= ebit_d;
      under_q   <= under_d;
    end
  end

  assign PARALLEL_OUT = word_q;
  assign EDGE_FLAG    = eflag_q;
  assign EDGE_BIT     = ebit_q;
  assign UNDERRUN     = under_q;

`ifdef OVERSAMPLING_SERIALIZER_EDGE_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  assign cnt_d = eflag_d ? cnt_q + 32'd1 : cnt_q;

  always_ff @(posedge CLK_PARALLEL) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign EDGE_COUNT = cnt_q;
`endif

endmodule

// File: tb/tb_oversampling_edge_serializer.sv
// Randomized bench for oversampling_edge_serializer against an
// absolute-timeline edge model (edges at cumulative clamped intervals).
module tb_oversampling_edge_serializer;

  logic        clk;
  logic        rst;
  logic        en;
  logic        dvalid;
  logic        dready;
  logic [19:0] din;
  logic [63:0] pout;
  logic        eflag;
  logic [5:0]  ebit;
  logic        under;
`ifdef OVERSAMPLING_SERIALIZER_EDGE_COUNT_EN
  logic [31:0] ecount;
`endif

  oversampling_edge_serializer #(.DELAY_WIDTH(20)) dut (
    .CLK_PARALLEL(clk),
    .RESET(rst),
    .ENABLE(en),
    .DELAY_VALID(dvalid),
    .DELAY_READY(dready),
    .DELAY_IN(din),
    .PARALLEL_OUT(pout),
    .EDGE_FLAG(eflag),
    .EDGE_BIT(ebit),
    .UNDERRUN(under)
`ifdef OVERSAMPLING_SERIALIZER_EDGE_COUNT_EN
    ,
    .EDGE_COUNT(ecount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int      n_chk;
  int      n_err;
  logic    mlvl;
  logic    munder;
  int      mcnt;
  int      offq[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag,
                          input logic [63:0] w,
                          input logic f,
                          input logic [5:0] b);
    chk({tag, ".word"}, pout, w);
    chk({tag, ".flag"}, 64'(eflag), 64'(f));
    chk({tag, ".bit"}, 64'(ebit), 64'(b));
    chk({tag, ".under"}, 64'(under), 64'(munder));
`ifdef OVERSAMPLING_SERIALIZER_EDGE_COUNT_EN
    chk({tag, ".count"}, 64'(ecount), 64'(mcnt));
`endif
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    en     = 1'b1;
    dvalid = 1'b1;
    din    = 20'd77;
    @(negedge clk);
    chk("rst.ready_low", 64'(dready), 64'd0);
    @(posedge clk); #1;
    mlvl   = 1'b0;
    munder = 1'b0;
    mcnt   = 0;
    @(negedge clk);
    chk("rst.ready_low2", 64'(dready), 64'd0);
    chk_outs("rst", 64'd0, 1'b0, 6'd0);
    @(posedge clk); #1;
    rst    = 1'b0;
    dvalid = 1'b0;
    din    = '0;
    en     = 1'b0;
    @(negedge clk);
    chk("rst.ready_high", 64'(dready), 64'd1);
    @(posedge clk); #1;
  endtask

  // Offers offq continuously; edges fall at cumulative clamped sums,
  // measured from bit 0 of the first armed word.
  task automatic run(input string tag, input logic enable, input int ncyc);
    int     c0;
    int     nacc;
    int     ei;
    longint esum;
    longint etq[$];
    longint base;
    longint p;
    int     d;
    logic [63:0] ew;
    logic        ef;
    logic [5:0]  eb;
    c0   = -1;
    nacc = 0;
    ei   = 0;
    esum = 0;
    en   = enable;
    for (int c = 0; c < ncyc; c++) begin
      dvalid = (nacc < offq.size());
      din    = dvalid ? 20'(offq[nacc]) : 20'd0;
      @(negedge clk);
      ew = {64{mlvl}};
      ef = 1'b0;
      eb = 6'd0;
      if (c0 >= 0 && c >= c0 + 3) begin
        base = 64 * longint'(c - c0 - 3);
        if (ei < etq.size() && etq[ei] < base + 64) begin
          p = etq[ei] - base;
          for (int i = 0; i < 64; i++) begin
            ew[i] = (i < p) ? mlvl : ~mlvl;
          end
          ef   = 1'b1;
          eb   = 6'(p);
          mlvl = ~mlvl;
          mcnt++;
          if (ei == offq.size() - 1) munder = 1'b1;
          ei++;
        end
      end
      chk_outs(tag, ew, ef, eb);
      if (dvalid && dready) begin
        d    = (offq[nacc] < 64) ? 64 : offq[nacc];
        esum += d;
        etq.push_back(esum);
        if (c0 < 0) c0 = c;
        nacc++;
      end
      @(posedge clk); #1;
    end
    dvalid = 1'b0;
    din    = '0;
  endtask

  initial begin
    int tot;
    n_chk  = 0;
    n_err  = 0;
    mlvl   = 1'b0;
    munder = 1'b0;
    mcnt   = 0;
    rst    = 1'b1;
    en     = 1'b0;
    dvalid = 1'b0;
    din    = '0;

    do_reset();
    offq = {};
    run("idle", 1'b0, 5);

    offq = {100};
    for (int i = 0; i < 12; i++) offq.push_back(128);
    run("d100", 1'b1, 40);

    do_reset();
    offq = {100};
    for (int i = 0; i < 8; i++) offq.push_back(40);
    run("clamp", 1'b1, 20);

    do_reset();
    offq = {70};
    run("underrun", 1'b1, 12);
    chk("underrun.level", 64'(pout), {64{1'b1}});

    do_reset();
    offq = {};
    tot  = 0;
    for (int i = 0; i < 200; i++) begin
      offq.push_back(int'($urandom_range(5000, 64)));
      tot += offq[i];
    end
    run("rand", 1'b1, tot / 64 + 12);

    do_reset();
    offq = {};
    tot  = 0;
    for (int i = 0; i < 60; i++) begin
      offq.push_back(int'($urandom_range(400, 20)));
    end
    run("midarm", 1'b1, 40);
    do_reset();
    offq = {};
    run("postrst", 1'b1, 12);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
